// File: rtl/pulse_train_generator.sv
// Programmable burst of rectangular pulses with start/busy/done handshake and abort.
// Define PULSE_TRAIN_GEN_CONTINUOUS_EN to make a latched pulse_cnt of 0 an endless burst.
module pulse_train_generator #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] pulse_cnt,
  output logic             out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] pulses_q, pulses_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             inf_q, inf_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             inf_start;
  logic [CNT_W-1:0] high_m1, low_m1;

`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
  assign inf_start = (pulse_cnt == '0);
`else
  assign inf_start = 1'b0;
`endif

  // Phase lengths are held as (length - 1) with 0 clamped to a one-cycle phase.
  assign high_m1 = (high_len == '0) ? '0 : high_len - CNT_W'(1);
  assign low_m1  = (low_len == '0) ? '0 : low_len - CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    high_d   = high_q;
    low_d    = low_q;
    pulses_d = pulses_q;
    phase_d  = phase_q;
    inf_d    = inf_q;
    if (abort) begin
      state_d = StIdle;
      phase_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            high_d   = high_m1;
            low_d    = low_m1;
            pulses_d = pulse_cnt;
            inf_d    = inf_start;
            if (pulse_cnt != '0 || inf_start) begin
              state_d = StHigh;
              phase_d = high_m1;
            end
          end
        end
        StHigh: begin
          if (phase_q == '0) begin
            state_d = StLow;
            phase_d = low_q;
          end else begin
            phase_d = phase_q - CNT_W'(1);
          end
        end
        StLow: begin
          if (phase_q != '0) begin
            phase_d = phase_q - CNT_W'(1);
          end else if (!inf_q && pulses_q == CNT_W'(1)) begin
            state_d  = StIdle;
            pulses_d = '0;
          end else begin
            state_d = StHigh;
            phase_d = high_q;
            if (!inf_q) begin
              pulses_d = pulses_q - CNT_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are computed from the next state so they can be registered without lag.
  always_comb begin
    out_d  = (state_d == StHigh);
    busy_d = (state_d != StIdle);
    done_d = !abort && (state_d == StIdle) &&
             ((state_q == StLow) || (state_q == StIdle && start));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_q   <= '0;
      low_q    <= '0;
      pulses_q <= '0;
      phase_q  <= '0;
      inf_q    <= 1'b0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      high_q   <= high_d;
      low_q    <= low_d;
      pulses_q <= pulses_d;
      phase_q  <= phase_d;
      inf_q    <= inf_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Randomized bench for pulse_train_generator against an arithmetic burst-timing model.
module tb_pulse_train_generator;

  localparam int unsigned CntW = 8;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
  localparam bit Cont = 1'b1;
`else
  localparam bit Cont = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [CntW-1:0] high_len;
  logic [CntW-1:0] low_len;
  logic [CntW-1:0] pulse_cnt;
  logic            out;
  logic            busy;
  logic            done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: burst accepted at edge ending cycle m_s; cycle c has t = c - m_s.
  bit m_act;
  bit m_inf;
  int m_s, m_h, m_l, m_n, m_done;

  always #5 clk = ~clk;

  pulse_train_generator #(.CNT_W(CntW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .high_len (high_len),
    .low_len  (low_len),
    .pulse_cnt(pulse_cnt),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  task automatic m_reset();
    m_act  = 1'b0;
    m_inf  = 1'b0;
    m_s    = 0;
    m_h    = 1;
    m_l    = 1;
    m_n    = 0;
    m_done = -1;
  endtask

  function automatic logic [2:0] exp_vec(input int c);
    int t;
    int p;
    bit b;
    bit o;
    t = c - m_s;
    p = m_h + m_l;
    b = m_act && t >= 1 && (m_inf || t <= m_n * p);
    o = b ? (((t - 1) % p) < m_h) : 1'b0;
    return {o, b, (c == m_done)};
  endfunction

  task automatic model_update(input int c, input bit st, input bit ab);
    bit busy_now;
    int h;
    int l;
    int n;
    busy_now = m_act && (m_inf || (c - m_s) <= m_n * (m_h + m_l));
    if (!rst) begin
      m_reset();
    end else if (ab) begin
      m_act = 1'b0;
      if (m_done > c) m_done = -1;
    end else if (st && !busy_now) begin
      h = (int'(high_len) == 0) ? 1 : int'(high_len);
      l = (int'(low_len) == 0) ? 1 : int'(low_len);
      n = int'(pulse_cnt);
      if (n == 0 && !Cont) begin
        m_act  = 1'b0;
        m_done = c + 1;
      end else begin
        m_act  = 1'b1;
        m_s    = c;
        m_h    = h;
        m_l    = l;
        m_n    = n;
        m_inf  = (n == 0);
        m_done = m_inf ? -1 : c + n * (h + l) + 1;
      end
    end
  endtask

  // Called at a negedge: drive inputs, cross one active edge, return at the next negedge.
  task automatic tick(input bit st, input bit ab, input int h, input int l, input int n);
    start = st;
    abort = ab;
    if (st) begin
      high_len  = CntW'(h);
      low_len   = CntW'(l);
      pulse_cnt = CntW'(n);
    end else begin
      high_len  = CntW'($urandom);
      low_len   = CntW'($urandom);
      pulse_cnt = CntW'($urandom);
    end
    @(posedge clk);
    model_update(cyc, st, ab);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    high_len = '0;
    low_len = '0;
    pulse_cnt = '0;
    m_reset();
    @(negedge clk);
    tick(1'b1, 1'b0, 3, 3, 3);
    n_cmp++;
    if ({out, busy, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_state: out/busy/done=%b want 000", {out, busy, done});
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b0, 0, 0, 0);
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL reset_idle cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
    end
  endtask

  task automatic test_basic();
    int pc;
    bit prev;
    pc = 0;
    prev = 1'b0;
    tick(1'b1, 1'b0, 1, 1, 3);
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL basic cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
      if (out && !prev) pc++;
      prev = out;
      tick(1'b0, 1'b0, 0, 0, 0);
    end
    n_cmp++;
    if (pc !== 3) begin
      n_bad++;
      $display("FAIL basic_pulse_count: got %0d want 3", pc);
    end
  endtask

  task automatic test_clamp();
    tick(1'b1, 1'b0, 0, 2, 2);
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL clamp cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
      tick(1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  task automatic test_start_busy();
    int dc;
    dc = 0;
    tick(1'b1, 1'b0, 3, 3, 2);
    for (int k = 1; k <= 15; k++) begin
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL start_busy cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
      if (done) dc++;
      tick(k == 4, 1'b0, int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), 4);
    end
    n_cmp++;
    if (dc !== 1) begin
      n_bad++;
      $display("FAIL start_busy_done_count: got %0d want 1", dc);
    end
  endtask

  task automatic test_abort();
    int dc;
    dc = 0;
    tick(1'b1, 1'b0, 4, 4, 5);
    for (int k = 1; k <= 10; k++) begin
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL abort cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
      if (done) dc++;
      tick(1'b0, k == 6, 0, 0, 0);
    end
    n_cmp++;
    if (dc !== 0) begin
      n_bad++;
      $display("FAIL abort_done_count: got %0d want 0", dc);
    end
    tick(1'b1, 1'b1, 2, 2, 2);
    tick(1'b1, 1'b0, 1, 1, 1);
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL after_abort cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
      tick(1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  task automatic test_empty();
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
    tick(1'b1, 1'b0, 2, 1, 0);
    for (int k = 1; k <= 36; k++) begin
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL continuous cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
      tick(1'b0, k == 33, 0, 0, 0);
    end
`else
    tick(1'b1, 1'b0, 5, 5, 0);
    for (int k = 1; k <= 3; k++) begin
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL empty cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
      tick(1'b0, 1'b0, 0, 0, 0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int started;
    started = 1;
    tick(1'b1, 1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
         int'($urandom_range(1, 3)));
    for (int k = 0; k < 100; k++) begin
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
      if (cyc == m_done && started < 4) begin
        started++;
        tick(1'b1, 1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(1, 3)));
      end else begin
        tick(1'b0, 1'b0, 0, 0, 0);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
      tick(($urandom % 4) == 0, ($urandom % 25) == 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    tick(1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b0, 5, 2, 2);
    tick(1'b0, 1'b0, 0, 0, 0);
    n_cmp++;
    if ({out, busy, done} !== exp_vec(cyc)) begin
      n_bad++;
      $display("FAIL pre_reset cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
    end
    #2 rst = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if ({out, busy, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_reset: out/busy/done=%b want 000", {out, busy, done});
    end
    @(negedge clk);
    tick(1'b0, 1'b0, 0, 0, 0);
    rst = 1'b1;
    tick(1'b1, 1'b0, 1, 2, 2);
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if ({out, busy, done} !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL post_reset cyc %0d: got %b want %b", cyc, {out, busy, done}, exp_vec(cyc));
      end
      tick(1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_start_busy();
    test_abort();
    test_empty();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
# pulse_train_generator

Sequential stimulus source that drives a single-bit line with a programmable burst of rectangular pulses. It is the transmit-side counterpart of the posedge and one-cycle-pulse detectors: it produces the waveforms those detectors consume. Typical uses are benches and on-chip self-test, where its output feeds a detector input directly. A start/busy/done handshake sequences the bursts, and an abort input cancels a burst in flight.

## Interface

- `CNT_W`, default 8: width of all length and count fields.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset. `rst = 0` resets immediately; release is synchronous to `clk` by the system.
- `start`  input  1  burst request, sampled only in IDLE.
- `abort`  input  1  cancel the current burst; highest priority after reset.
- `high_len`  input  CNT_W  high-phase length in cycles, latched on start.
- `low_len`  input  CNT_W  low-phase length in cycles, latched on start.
- `pulse_cnt`  input  CNT_W  number of pulses in the burst, latched on start.
- `out`  output  1  generated waveform, registered.
- `busy`  output  1  burst in progress, registered.
- `done`  output  1  one-cycle completion strobe, registered.

## Operation

- FSM states: IDLE, HIGH, LOW.
- Reset values: state IDLE, `out`=0, `busy`=0, `done`=0, all counters 0.
- IDLE with `start`=1 and `abort`=0:
  - Latch `high_len`, `low_len`, `pulse_cnt`.
  - A latched length of 0 is treated as 1.
  - If latched `pulse_cnt` ≠ 0: go to HIGH.
  - If latched `pulse_cnt` = 0: stay in IDLE and assert `done` for one cycle (empty burst).
- HIGH: `out`=1 for exactly H cycles, then go to LOW.
- LOW: `out`=0 for exactly L cycles.
  - If pulses remain, go to HIGH.
  - Otherwise go to IDLE and assert `done` for one cycle.
- Every pulse, including the last, is followed by its full low phase, so back-to-back bursts stay separated by at least L zeros.
- `start` while `busy`=1: ignored. It is not queued.
- `abort`=1 in HIGH or LOW: next edge goes to IDLE with `out`=0 and `busy`=0. `done` is not asserted.
- `abort` and `start` both high in IDLE: `abort` wins and nothing starts.
- Reset asserted mid-burst: all outputs go to reset values immediately. The burst is lost.
- Counters are CNT_W bits wide and never wrap. The maximum phase is 2^CNT_W−1 cycles; the maximum burst is 2^CNT_W−1 pulses.

## Timing

- `start` is sampled at edge E0.
- `out` and `busy` rise after E0. The first high cycle is the cycle following E0.
- `out` is high for cycles 1..H, low for H+1..H+L, then repeats.
- Total busy time is N·(H+L) cycles.
- `done`=1 during cycle N·(H+L)+1 after E0. `busy` falls in that same cycle.
- A new `start` may be applied in the `done` cycle. It is sampled because the FSM is already in IDLE, so bursts run back to back with no gap cycle.
- Empty burst: `done`=1 in the cycle after E0. `busy` stays 0 and `out` stays 0.
- `out` is glitch-free: driven directly from a flop, with no combinational path from any input.

## Configuration

- `PULSE_TRAIN_GEN_CONTINUOUS_EN`
  - Defined: a latched `pulse_cnt` of 0 means an infinite burst. The generator alternates HIGH/LOW indefinitely with `busy`=1, and only `abort` or reset ends it. `done` is never asserted for such a burst.
  - Undefined: `pulse_cnt` = 0 is an empty burst, as described in Operation.
- Port list and all other behaviour are identical in both builds.

## Test plan

- Basic burst: reset, then `start` with H=1, L=1, N=3 → `out` = 1,0,1,0,1,0 over cycles 1–6. `busy` is high for cycles 1–6. `done` is high in cycle 7 only. A one-cycle-pulse detector on `out` must flag all three pulses.
- Zero-length clamp: H=0, L=2, N=2 → `out` = 1,0,0,1,0,0. `done` in cycle 7.
- Start while busy: H=3, L=3, N=2, with `start` re-pulsed at cycle 4 → the burst is unchanged, a single `done` at cycle 13, then IDLE.
- Abort: H=4, L=4, N=5, with `abort` at cycle 6 → `out`=0 and `busy`=0 from cycle 7. `done` never asserts. A following `start` with H=1, L=1, N=1 runs normally.
- N=0 handling:
  - Macro undefined: `start` → `done` in cycle 1, `out` stays 0.
  - Macro defined: `out` alternates with H=2, L=1 for at least 30 cycles, then `abort` stops it.
- Asynchronous reset: drop `rst` mid-HIGH with no clock edge → `out`, `busy` and `done` go to 0 immediately. After release, behaviour is the same as after power-on.
